// File: rtl/cog_vcap.sv
// Video/pin capture: samples 1 or 2 bits per pixel from one synchronized pin byte,
// packs them into 32-bit longs and hands them to the cog through a ready/get holding register.
//   state | meaning
//   IDLE  | capture stopped, holding register still readable
//   ARM   | counters loaded, waiting for the selected trigger edge
//   RUN   | counting pixels/frames, one long per frame
module cog_vcap #(
  parameter int CNT_W = 8,
  parameter int SET_W = 12
) (
  input  logic        clk_cog,
  input  logic        nres,
  input  logic        setcap,
  input  logic        setscl,
  input  logic        getcap,
  input  logic [31:0] data,
  input  logic [31:0] pin_in,
  output logic [31:0] cap_data,
  output logic        ready,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t                   state, state_nxt;
  logic                     cfg_bpp2, cfg_pol;
  logic [2:0]               cfg_bt, cfg_b;
  logic [1:0]               cfg_g;
  logic [CNT_W+SET_W-1:0]   scl;
  logic [7:0]               sel_byte, s1, s2, s_d;
  logic [CNT_W-1:0]         pcnt, scl_p;
  logic [SET_W-1:0]         fcnt, scl_f;
  logic [31:0]              sh, sh_shift;
  logic [2:0]               b_nx;
  logic                     frame_end, pix, trig_edge, count_en, frame_evt;
  logic                     unused_bits;

  assign unused_bits = ^{data[31:30], data[25:16], data[12:11], data[8:3]};

  assign scl_p = scl[CNT_W+SET_W-1 -: CNT_W];
  assign scl_f = scl[SET_W-1:0];

  always_comb begin
    sel_byte = pin_in[7:0];
    case (cfg_g)
      2'd0: sel_byte = pin_in[7:0];
      2'd1: sel_byte = pin_in[15:8];
      2'd2: sel_byte = pin_in[23:16];
      2'd3: sel_byte = pin_in[31:24];
      default: sel_byte = pin_in[7:0];
    endcase
  end

  // 3-bit add wraps the second sample bit within the byte
  assign b_nx     = cfg_b + 3'd1;
  assign sh_shift = cfg_bpp2 ? {s2[b_nx], s2[cfg_b], sh[31:2]} : {s2[cfg_b], sh[31:1]};

  assign frame_end = (fcnt == SET_W'(1));
  assign pix       = (pcnt == CNT_W'(1)) | frame_end;
  assign trig_edge = cfg_pol ? (s2[cfg_bt] & ~s_d[cfg_bt]) : (~s2[cfg_bt] & s_d[cfg_bt]);
  // the trigger edge cycle already counts as the first RUN cycle
  assign count_en  = !setcap && ((state == S_RUN) || (state == S_ARM && trig_edge));
  assign frame_evt = count_en & frame_end;

  always_comb begin
    state_nxt = state;
    if (setcap)
      state_nxt = data[29] ? (data[27] ? S_ARM : S_RUN) : S_IDLE;
    else if (state == S_ARM && trig_edge)
      state_nxt = S_RUN;
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      cfg_bpp2 <= 1'b0;
      cfg_pol  <= 1'b0;
      cfg_bt   <= '0;
      cfg_g    <= '0;
      cfg_b    <= '0;
      scl      <= '0;
      s1       <= '0;
      s2       <= '0;
      s_d      <= '0;
    end else begin
      if (setcap) begin
        cfg_bpp2 <= data[28];
        cfg_pol  <= data[26];
        cfg_bt   <= data[15:13];
        cfg_g    <= data[10:9];
        cfg_b    <= data[2:0];
      end
      if (setscl)
        scl <= data[CNT_W+SET_W-1:0];
      s1  <= sel_byte;
      s2  <= s1;
      s_d <= s2;
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      pcnt <= '0;
      fcnt <= '0;
      sh   <= '0;
    end else if (setcap && data[29]) begin
      pcnt <= scl_p;
      fcnt <= scl_f;
      sh   <= '0;
    end else if (count_en) begin
      if (frame_end) begin
        pcnt <= scl_p;
        fcnt <= scl_f;
        sh   <= '0;
      end else if (pix) begin
        pcnt <= scl_p;
        fcnt <= fcnt - SET_W'(1);
        sh   <= sh_shift;
      end else begin
        pcnt <= pcnt - CNT_W'(1);
        fcnt <= fcnt - SET_W'(1);
      end
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      cap_data <= '0;
      ready    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (frame_evt) begin
        if (!ready || getcap)
          cap_data <= sh_shift;
        ready <= 1'b1;
      end else if (getcap && ready) begin
        ready <= 1'b0;
      end
      if (setcap)
        overflow <= 1'b0;
      else if (frame_evt && ready && !getcap)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cog_vcap.sv
// Directed bench for cog_vcap: capture patterns, trigger, overflow/handshake and reset.
module tb_cog_vcap;
  logic        clk_cog = 1'b0;
  logic        nres, setcap, setscl, getcap;
  logic [31:0] data, pin_in, cap_data;
  logic        ready, overflow, busy;
  logic        tog_en;
  int          checks = 0;
  int          errors = 0;

  cog_vcap dut (
    .clk_cog(clk_cog), .nres(nres), .setcap(setcap), .setscl(setscl),
    .getcap(getcap), .data(data), .pin_in(pin_in), .cap_data(cap_data),
    .ready(ready), .overflow(overflow), .busy(busy)
  );

  always #5 clk_cog = ~clk_cog;

  task automatic tick();
    @(posedge clk_cog);
    #1;
    if (tog_en) pin_in[0] = ~pin_in[0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    nres = 1'b0; setcap = 1'b0; setscl = 1'b0; getcap = 1'b0;
    data = '0; pin_in = '0; tog_en = 1'b0;
    tick(); tick();
    chk("rst_cap", cap_data, 32'h0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    nres = 1'b1;
    tick();

    // 1bpp, pin0 alternating 1,0,... from the first sample -> 5555_5555 every 32 clocks
    setscl = 1'b1; data = 32'h0000_1020;
    tick();
    setscl = 1'b0;
    pin_in[0] = 1'b1; tog_en = 1'b1;
    tick();
    setcap = 1'b1; data = 32'h2000_0000;
    tick();                               // j=0
    setcap = 1'b0;
    chk("t1_busy", busy, 1'b1);
    repeat (31) tick();                   // j=31
    chk("t1_ready_early", ready, 1'b0);
    tick();                               // j=32
    chk("t1_ready", ready, 1'b1);
    chk("t1_word", cap_data, 32'h5555_5555);
    getcap = 1'b1;
    tick();
    getcap = 1'b0;
    chk("t1_pop", ready, 1'b0);
    repeat (30) tick();                   // j=63
    chk("t1_ready2_early", ready, 1'b0);
    tick();
    chk("t1_ready2", ready, 1'b1);
    chk("t1_word2", cap_data, 32'h5555_5555);
    tog_en = 1'b0;

    // 2bpp, group 1, b=7 wraps to bit 0: {s[0],s[7]} = 2'b10 -> AAAA_AAAA
    getcap = 1'b1; pin_in = 32'h0000_0180;
    setscl = 1'b1; data = 32'h0000_2020;
    tick();
    getcap = 1'b0; setscl = 1'b0;
    setcap = 1'b1; data = 32'h1000_0207;
    tick();
    chk("t2_idle", busy, 1'b0);
    data = 32'h3000_0207;
    tick();                               // j=0
    setcap = 1'b0;
    repeat (31) tick();
    chk("t2_ready_early", ready, 1'b0);
    tick();
    chk("t2_ready", ready, 1'b1);
    chk("t2_word", cap_data, 32'hAAAA_AAAA);

    // trigger wait on rising pin3; pin0 high -> FFFF_FFFF
    getcap = 1'b1; pin_in = 32'h0000_0001;
    setscl = 1'b1; data = 32'h0000_1020;
    tick();
    getcap = 1'b0; setscl = 1'b0;
    setcap = 1'b1; data = 32'h2C00_6000;
    tick();
    setcap = 1'b0;
    repeat (50) tick();
    chk("t3_armed_busy", busy, 1'b1);
    chk("t3_armed_ready", ready, 1'b0);
    pin_in[3] = 1'b1;                     // cycle R
    tick(); tick();                       // R+2: synchronized edge, j=0
    repeat (31) tick();                   // R+33
    chk("t3_ready_early", ready, 1'b0);
    tick();                               // R+34
    chk("t3_ready", ready, 1'b1);
    chk("t3_word", cap_data, 32'hFFFF_FFFF);

    // no getcap for the next frame -> overflow, first word kept
    pin_in[0] = 1'b0;
    repeat (31) tick();                   // j=63
    chk("t4_no_ovf_yet", overflow, 1'b0);
    tick();                               // j=64
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_word_kept", cap_data, 32'hFFFF_FFFF);
    chk("t4_ready_kept", ready, 1'b1);
    repeat (31) tick();                   // j=95, frame_end
    getcap = 1'b1;
    tick();
    getcap = 1'b0;
    chk("t4_get_fe_ready", ready, 1'b1);
    chk("t4_get_fe_word", cap_data, 32'h0000_0000);
    chk("t4_get_fe_ovf", overflow, 1'b1);
    repeat (5) tick();
    setcap = 1'b1; data = 32'h0000_0000;
    tick();
    setcap = 1'b0;
    chk("t4_stop_busy", busy, 1'b0);
    chk("t4_stop_ready", ready, 1'b1);
    chk("t4_stop_ovf", overflow, 1'b0);
    repeat (40) tick();
    chk("t4_idle_ready", ready, 1'b1);
    chk("t4_idle_ovf", overflow, 1'b0);

    // setscl mid-frame takes effect at the next reload, then reset mid-frame
    getcap = 1'b1; pin_in = 32'h0000_0001;
    tick();
    getcap = 1'b0;
    setcap = 1'b1; data = 32'h2000_0000;
    tick();                               // j=0
    setcap = 1'b0;
    repeat (31) tick();
    chk("t5_ready_early", ready, 1'b0);
    tick();                               // j=32
    chk("t5_ready", ready, 1'b1);
    chk("t5_word", cap_data, 32'hFFFF_FFFF);
    getcap = 1'b1; setscl = 1'b1; data = 32'h0000_1010;
    tick();
    getcap = 1'b0; setscl = 1'b0;
    repeat (30) tick();                   // j=63, frame still 32 long
    chk("t5_old_len", ready, 1'b0);
    tick();
    chk("t5_old_len_end", ready, 1'b1);
    getcap = 1'b1;
    tick();
    getcap = 1'b0;
    repeat (14) tick();                   // j=79
    chk("t5_new_len_early", ready, 1'b0);
    tick();
    chk("t5_new_len", ready, 1'b1);
    chk("t5_new_ovf", overflow, 1'b0);
    repeat (5) tick();
    #3;
    nres = 1'b0;
    #1;
    chk("t5_rst_cap", cap_data, 32'h0);
    chk("t5_rst_ready", ready, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_ovf", overflow, 1'b0);
    #7;
    nres = 1'b1;
    repeat (40) tick();
    chk("t5_post_busy", busy, 1'b0);
    chk("t5_post_ready", ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
